// File: rtl/dual_core_ram_arbiter.sv
// dual_core_ram_arbiter
//   Shares one simple dual-port RAM (one registered write port, one async
//   read port) between core 0 and core 1. The write port and the read port
//   each have their own round-robin arbiter with its own "last winner"
//   pointer. All state is on wr_clk; reset is asynchronous and active-high.
//
//   Optional feature macro: RAM_ARB_FWD_EN
//     defined   -> a read accepted while the registered write port targets
//                  the same address captures the write data (forwarding).
//     undefined -> read data is always taken from the RAM's async output.
//
// Handshake: a core raises cN_*_req and holds its address (and data) steady
//   until it sees cN_*_gnt; the request is accepted on the rising edge where
//   req && gnt are both high. gnt is combinational and never high without
//   its own req. Read results come back as a 1-cycle cN_rd_valid pulse with
//   cN_rd_data, one cycle after the accepting edge.

module dual_core_ram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  wr_clk,
    input  logic                  reset,

    input  logic                  c0_wr_req,
    input  logic [ADDR_WIDTH-1:0] c0_wr_addr,
    input  logic [DATA_WIDTH-1:0] c0_wr_data,
    output logic                  c0_wr_gnt,
    input  logic                  c0_rd_req,
    input  logic [ADDR_WIDTH-1:0] c0_rd_addr,
    output logic                  c0_rd_gnt,
    output logic                  c0_rd_valid,
    output logic [DATA_WIDTH-1:0] c0_rd_data,

    input  logic                  c1_wr_req,
    input  logic [ADDR_WIDTH-1:0] c1_wr_addr,
    input  logic [DATA_WIDTH-1:0] c1_wr_data,
    output logic                  c1_wr_gnt,
    input  logic                  c1_rd_req,
    input  logic [ADDR_WIDTH-1:0] c1_rd_addr,
    output logic                  c1_rd_gnt,
    output logic                  c1_rd_valid,
    output logic [DATA_WIDTH-1:0] c1_rd_data,

    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_read_data
);

    // Last winner of each port: 0 = core 0, 1 = core 1. Reset to 1 so that
    // core 0 wins the first tie.
    logic                  wr_last;
    logic                  rd_last;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [DATA_WIDTH-1:0] rd_capture;

    // Round-robin: a lone request always wins; on a tie the core that did
    // not win last time is granted.
    assign c0_wr_gnt = c0_wr_req & (~c1_wr_req | wr_last);
    assign c1_wr_gnt = c1_wr_req & (~c0_wr_req | ~wr_last);
    assign c0_rd_gnt = c0_rd_req & (~c1_rd_req | rd_last);
    assign c1_rd_gnt = c1_rd_req & (~c0_rd_req | ~rd_last);

    assign wr_accept = c0_wr_gnt | c1_wr_gnt;
    assign rd_accept = c0_rd_gnt | c1_rd_gnt;

    // Steer the granted core's read address to the RAM; idle reads address 0.
    always_comb begin
        ram_read_addr = '0;
        if (c0_rd_gnt) begin
            ram_read_addr = c0_rd_addr;
        end else if (c1_rd_gnt) begin
            ram_read_addr = c1_rd_addr;
        end
    end

`ifdef RAM_ARB_FWD_EN
    // The registered write lands in the RAM only at the next edge, so a read
    // of the same address in this cycle takes the in-flight write data.
    assign rd_capture = (ram_wr_en && (ram_write_addr == ram_read_addr)) ?
                        ram_write_data : ram_read_data;
`else
    // No forwarding: a read racing the in-flight write returns old data.
    assign rd_capture = ram_read_data;
`endif

    // Write port: register the winner's address/data, pulse ram_wr_en once
    // per accepted write, and move the write pointer to the winner.
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            wr_last        <= 1'b1;
            ram_wr_en      <= 1'b0;
            ram_write_addr <= '0;
            ram_write_data <= '0;
        end else begin
            ram_wr_en <= wr_accept;
            if (wr_accept) begin
                wr_last        <= c1_wr_gnt;
                ram_write_addr <= c1_wr_gnt ? c1_wr_addr : c0_wr_addr;
                ram_write_data <= c1_wr_gnt ? c1_wr_data : c0_wr_data;
            end
        end
    end

    // Read port: capture the RAM output into the winner's data register,
    // pulse its valid for one cycle and move the read pointer to the winner.
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            rd_last     <= 1'b1;
            c0_rd_valid <= 1'b0;
            c1_rd_valid <= 1'b0;
            c0_rd_data  <= '0;
            c1_rd_data  <= '0;
        end else begin
            c0_rd_valid <= c0_rd_gnt;
            c1_rd_valid <= c1_rd_gnt;
            if (rd_accept) begin
                rd_last <= c1_rd_gnt;
            end
            if (c0_rd_gnt) begin
                c0_rd_data <= rd_capture;
            end
            if (c1_rd_gnt) begin
                c1_rd_data <= rd_capture;
            end
        end
    end

endmodule

// File: tb/tb_dual_core_ram_arbiter.sv
// tb_dual_core_ram_arbiter
//   Bench for dual_core_ram_arbiter with a behavioural RAM attached to the
//   RAM ports. Build with +define+RAM_ARB_FWD_EN to check the forwarding
//   variant; the expected RAW result follows the same macro.

module tb_dual_core_ram_arbiter;

    localparam int DW = 32;
    localparam int AW = 8;

`ifdef RAM_ARB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic wr_clk = 1'b0;
    logic reset;
    always #5 wr_clk = ~wr_clk;

    // ---------------- DUT signals ----------------
    logic          c0_wr_req, c1_wr_req, c0_rd_req, c1_rd_req;
    logic [AW-1:0] c0_wr_addr, c1_wr_addr, c0_rd_addr, c1_rd_addr;
    logic [DW-1:0] c0_wr_data, c1_wr_data;
    logic          c0_wr_gnt, c1_wr_gnt, c0_rd_gnt, c1_rd_gnt;
    logic          c0_rd_valid, c1_rd_valid;
    logic [DW-1:0] c0_rd_data, c1_rd_data;
    logic          ram_wr_en;
    logic [AW-1:0] ram_write_addr, ram_read_addr;
    logic [DW-1:0] ram_write_data, ram_read_data;

    dual_core_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .wr_clk         (wr_clk),
        .reset          (reset),
        .c0_wr_req      (c0_wr_req),
        .c0_wr_addr     (c0_wr_addr),
        .c0_wr_data     (c0_wr_data),
        .c0_wr_gnt      (c0_wr_gnt),
        .c0_rd_req      (c0_rd_req),
        .c0_rd_addr     (c0_rd_addr),
        .c0_rd_gnt      (c0_rd_gnt),
        .c0_rd_valid    (c0_rd_valid),
        .c0_rd_data     (c0_rd_data),
        .c1_wr_req      (c1_wr_req),
        .c1_wr_addr     (c1_wr_addr),
        .c1_wr_data     (c1_wr_data),
        .c1_wr_gnt      (c1_wr_gnt),
        .c1_rd_req      (c1_rd_req),
        .c1_rd_addr     (c1_rd_addr),
        .c1_rd_gnt      (c1_rd_gnt),
        .c1_rd_valid    (c1_rd_valid),
        .c1_rd_data     (c1_rd_data),
        .ram_wr_en      (ram_wr_en),
        .ram_write_addr (ram_write_addr),
        .ram_write_data (ram_write_data),
        .ram_read_addr  (ram_read_addr),
        .ram_read_data  (ram_read_data)
    );

    // ---------------- behavioural RAM ----------------
    logic [DW-1:0] ram_mem [256] = '{default: '0};
    always @(posedge wr_clk) begin
        if (ram_wr_en) ram_mem[ram_write_addr] <= ram_write_data;
    end
    assign ram_read_data = ram_mem[ram_read_addr];

    // ---------------- scoreboard / reference model ----------------
    int total = 0;
    int bad   = 0;

    // Model state: committed memory contents, the write in flight on the
    // registered write port, last winners, and expected per-core read results.
    logic [DW-1:0] m_mem [256];
    bit            pend_v;
    logic [AW-1:0] pend_a;
    logic [DW-1:0] pend_d;
    int            m_wr_last, m_rd_last;
    logic [DW-1:0] exp_rdd [2];
    bit            exp_rdv [2];
    int            ew_last, er_last;
    int            wr_cnt [2];
    int            rd_cnt [2];
    logic          g_c0w, g_c1w, g_c0r, g_c1r;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Winner by round-robin rule: -1 none, else core index.
    function automatic int pick(input bit r0, input bit r1, input int last);
        if (r0 && r1) return (last == 0) ? 1 : 0;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        pend_v    = 1'b0;
        m_wr_last = 1;
        m_rd_last = 1;
        for (int c = 0; c < 2; c++) begin
            exp_rdd[c] = '0;
            exp_rdv[c] = 1'b0;
        end
        ew_last = -1;
        er_last = -1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        c0_wr_req = 0; c1_wr_req = 0; c0_rd_req = 0; c1_rd_req = 0;
        c0_wr_addr = '0; c1_wr_addr = '0; c0_rd_addr = '0; c1_rd_addr = '0;
        c0_wr_data = '0; c1_wr_data = '0;
    endtask

    // One clock: check grants mid-cycle, advance the model at the edge,
    // check registered outputs just after the edge.
    task automatic do_cycle();
        int            ew, er;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        @(negedge wr_clk);
        ew = pick(c0_wr_req, c1_wr_req, m_wr_last);
        er = pick(c0_rd_req, c1_rd_req, m_rd_last);
        g_c0w = c0_wr_gnt; g_c1w = c1_wr_gnt; g_c0r = c0_rd_gnt; g_c1r = c1_rd_gnt;
        check("c0_wr_gnt", c0_wr_gnt, (ew == 0));
        check("c1_wr_gnt", c1_wr_gnt, (ew == 1));
        check("c0_rd_gnt", c0_rd_gnt, (er == 0));
        check("c1_rd_gnt", c1_rd_gnt, (er == 1));
        ra = (er == 0) ? c0_rd_addr : (er == 1) ? c1_rd_addr : '0;
        check("ram_read_addr", ram_read_addr, ra);
        @(posedge wr_clk);
        exp_rdv[0] = 1'b0;
        exp_rdv[1] = 1'b0;
        if (er >= 0) begin
            rd = m_mem[ra];
            if (FWD && pend_v && pend_a == ra) rd = pend_d;
            exp_rdd[er] = rd;
            exp_rdv[er] = 1'b1;
            m_rd_last   = er;
            rd_cnt[er]++;
        end
        if (pend_v) m_mem[pend_a] = pend_d;
        pend_v = 1'b0;
        if (ew >= 0) begin
            pend_v    = 1'b1;
            pend_a    = (ew == 0) ? c0_wr_addr : c1_wr_addr;
            pend_d    = (ew == 0) ? c0_wr_data : c1_wr_data;
            m_wr_last = ew;
            wr_cnt[ew]++;
        end
        ew_last = ew;
        er_last = er;
        #1;
        check("ram_wr_en", ram_wr_en, pend_v);
        if (pend_v) begin
            check("ram_write_addr", ram_write_addr, pend_a);
            check("ram_write_data", ram_write_data, pend_d);
        end
        check("c0_rd_valid", c0_rd_valid, exp_rdv[0]);
        check("c1_rd_valid", c1_rd_valid, exp_rdv[1]);
        check("c0_rd_data", c0_rd_data, exp_rdd[0]);
        check("c1_rd_data", c1_rd_data, exp_rdd[1]);
    endtask

    // Random requests that stay held until granted; all=1 keeps every
    // channel requesting. Small address range to provoke RAW collisions.
    task automatic rand_drive(input bit all);
        if (ew_last == 0 || !c0_wr_req) begin
            c0_wr_req  = all ? 1'b1 : 1'($urandom_range(0, 1));
            c0_wr_addr = AW'($urandom_range(0, 7));
            c0_wr_data = $urandom;
        end
        if (ew_last == 1 || !c1_wr_req) begin
            c1_wr_req  = all ? 1'b1 : 1'($urandom_range(0, 1));
            c1_wr_addr = AW'($urandom_range(0, 7));
            c1_wr_data = $urandom;
        end
        if (er_last == 0 || !c0_rd_req) begin
            c0_rd_req  = all ? 1'b1 : 1'($urandom_range(0, 1));
            c0_rd_addr = AW'($urandom_range(0, 7));
        end
        if (er_last == 1 || !c1_rd_req) begin
            c1_rd_req  = all ? 1'b1 : 1'($urandom_range(0, 1));
            c1_rd_addr = AW'($urandom_range(0, 7));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ram_wr_en"}, ram_wr_en, 0);
        check({tag, " ram_write_addr"}, ram_write_addr, 0);
        check({tag, " ram_write_data"}, ram_write_data, 0);
        check({tag, " c0_rd_valid"}, c0_rd_valid, 0);
        check({tag, " c1_rd_valid"}, c1_rd_valid, 0);
        check({tag, " c0_rd_data"}, c0_rd_data, 0);
        check({tag, " c1_rd_data"}, c1_rd_data, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          w0, w1, r0, r1;
        logic [AW-1:0] w0a, w1a, r0a, r1a;
        logic [DW-1:0] w0d, w1d;
        logic          ew0, ew1, er0, er1;
    } vec_t;

    vec_t vecs [12];

    initial begin
        // Expected grants hand-derived from the round-robin rule, starting
        // from reset (core 0 wins the first tie on each port).
        vecs[0]  = '{1,0,0,0, 8'h10,8'h00,8'h00,8'h00, 32'hDEAD,32'h0,   1,0,0,0};
        vecs[1]  = '{0,1,0,0, 8'h00,8'h11,8'h00,8'h00, 32'h0,32'h5555,   0,1,0,0};
        vecs[2]  = '{1,1,0,0, 8'h40,8'h50,8'h00,8'h00, 32'h400,32'h500,  1,0,0,0};
        vecs[3]  = '{1,1,0,0, 8'h41,8'h50,8'h00,8'h00, 32'h401,32'h500,  0,1,0,0};
        vecs[4]  = '{1,1,0,0, 8'h41,8'h51,8'h00,8'h00, 32'h401,32'h501,  1,0,0,0};
        vecs[5]  = '{1,1,0,0, 8'h42,8'h51,8'h00,8'h00, 32'h402,32'h501,  0,1,0,0};
        vecs[6]  = '{0,0,0,1, 8'h00,8'h00,8'h00,8'h10, 32'h0,32'h0,      0,0,0,1};
        vecs[7]  = '{0,1,1,1, 8'h00,8'h60,8'h40,8'h11, 32'h0,32'h600,    0,1,1,0};
        vecs[8]  = '{0,0,0,1, 8'h00,8'h00,8'h00,8'h11, 32'h0,32'h0,      0,0,0,1};
        vecs[9]  = '{0,0,1,1, 8'h00,8'h00,8'h50,8'h41, 32'h0,32'h0,      0,0,1,0};
        vecs[10] = '{0,0,0,1, 8'h00,8'h00,8'h00,8'h41, 32'h0,32'h0,      0,0,0,1};
        vecs[11] = '{0,0,0,0, 8'h00,8'h00,8'h00,8'h00, 32'h0,32'h0,      0,0,0,0};

        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        wr_cnt[0] = 0; wr_cnt[1] = 0; rd_cnt[0] = 0; rd_cnt[1] = 0;
        model_reset();
        set_idle();

        // ---- power-on reset ----
        reset = 1'b1;
        repeat (2) @(posedge wr_clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b0;

        // ---- table vectors: single writes, tie alternation, reads ----
        for (int i = 0; i < 12; i++) begin
            c0_wr_req = vecs[i].w0;  c1_wr_req = vecs[i].w1;
            c0_rd_req = vecs[i].r0;  c1_rd_req = vecs[i].r1;
            c0_wr_addr = vecs[i].w0a; c1_wr_addr = vecs[i].w1a;
            c0_rd_addr = vecs[i].r0a; c1_rd_addr = vecs[i].r1a;
            c0_wr_data = vecs[i].w0d; c1_wr_data = vecs[i].w1d;
            do_cycle();
            check($sformatf("vec%0d c0_wr_gnt", i), g_c0w, vecs[i].ew0);
            check($sformatf("vec%0d c1_wr_gnt", i), g_c1w, vecs[i].ew1);
            check($sformatf("vec%0d c0_rd_gnt", i), g_c0r, vecs[i].er0);
            check($sformatf("vec%0d c1_rd_gnt", i), g_c1r, vecs[i].er1);
        end

        // ---- lone write: granted same cycle, on the RAM port next cycle ----
        set_idle();
        c0_wr_req = 1; c0_wr_addr = 8'h70; c0_wr_data = 32'hDEAD;
        do_cycle();
        check("lone wr gnt", g_c0w, 1);
        check("lone wr en", ram_wr_en, 1);
        check("lone wr addr", ram_write_addr, 32'h70);
        check("lone wr data", ram_write_data, 32'hDEAD);
        set_idle();
        do_cycle();
        check("idle wr en", ram_wr_en, 0);

        // ---- c1 reads 0x10 long after it was written; c0 data untouched ----
        c1_rd_req = 1; c1_rd_addr = 8'h10;
        do_cycle();
        check("rd10 c1 valid", c1_rd_valid, 1);
        check("rd10 c1 data", c1_rd_data, 32'hDEAD);
        check("rd10 c0 valid", c0_rd_valid, 0);
        check("rd10 c0 data held", c0_rd_data, 32'h500);
        set_idle();
        do_cycle();
        check("rd10 c1 valid pulse", c1_rd_valid, 0);

        // ---- RAW: write 0x20 at T, read 0x20 at T+1, again later ----
        c0_wr_req = 1; c0_wr_addr = 8'h20; c0_wr_data = 32'h1234;
        do_cycle();
        set_idle();
        c1_rd_req = 1; c1_rd_addr = 8'h20;
        do_cycle();
        check("raw T+1 data", c1_rd_data, FWD ? 32'h1234 : 32'h0);
        set_idle();
        do_cycle();
        c0_rd_req = 1; c0_rd_addr = 8'h20;
        do_cycle();
        check("raw late data", c0_rd_data, 32'h1234);
        set_idle();
        do_cycle();

        // ---- everything requesting every cycle for 16 cycles ----
        wr_cnt[0] = 0; wr_cnt[1] = 0; rd_cnt[0] = 0; rd_cnt[1] = 0;
        for (int i = 0; i < 16; i++) begin
            rand_drive(1'b1);
            do_cycle();
        end
        check("full wr_cnt0", wr_cnt[0], 8);
        check("full wr_cnt1", wr_cnt[1], 8);
        check("full rd_cnt0", rd_cnt[0], 8);
        check("full rd_cnt1", rd_cnt[1], 8);

        // ---- random held requests against the model ----
        for (int i = 0; i < 400; i++) begin
            rand_drive(1'b0);
            do_cycle();
        end

        // ---- reset mid-burst: outputs clear at once, pending write dropped ----
        c0_wr_req = 1; c1_wr_req = 1; c0_rd_req = 1; c1_rd_req = 1;
        c0_wr_addr = 8'h30; c1_wr_addr = 8'h31; c0_wr_data = 32'hAAAA; c1_wr_data = 32'hBBBB;
        c0_rd_addr = 8'h10; c1_rd_addr = 8'h11;
        do_cycle();
        do_cycle();
        reset = 1'b1;
        #1;
        check_reset_outputs("mid");
        model_reset();
        @(posedge wr_clk);
        #1;
        reset = 1'b0;
        do_cycle();
        check("post-reset tie wr", g_c0w, 1);
        check("post-reset tie rd", g_c0r, 1);
        set_idle();
        repeat (3) do_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
